// File: rtl/scan_pkg.sv
// Shared definitions for the scan test controller: FSM state encoding and
// default chain / pattern-counter sizes.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DEF_CHAIN_LEN = 4;
  localparam int DEF_PAT_W     = 8;

endpackage

// File: rtl/scan_cmp.sv
// Response comparator: checks one scan_out bit per shift cycle against the
// expected vector and reports whether the current pattern had any mismatch.
module scan_cmp #(
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 last,
  input  logic [CHAIN_LEN-1:0] exp_vec,
  input  logic [CNT_W-1:0]     idx,
  input  logic                 scan_out,
  output logic                 pat_fail
);

  logic bit_mis;
  logic mis_reg;

  assign bit_mis  = en && (scan_out != exp_vec[idx]);
  // Includes the current bit so a mismatch on the final shift still counts.
  assign pat_fail = mis_reg | bit_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_reg <= 1'b0;
    end else if (last) begin
      mis_reg <= 1'b0;
    end else if (bit_mis) begin
      mis_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test controller: loads patterns, shifts them through the chain,
// pulses capture, and compares the unloaded response with the expected data.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int PAT_W     = DEF_PAT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PAT_W-1:0]     num_pat,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_stim,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 capture_en,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [PAT_W-1:0]     fail_cnt
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     shift_cnt;
  logic [CNT_W-1:0]     bit_idx;
  logic [PAT_W-1:0]     pat_cnt;
  logic [PAT_W-1:0]     num_pat_reg;
  logic [CHAIN_LEN-1:0] stim_reg;
  logic [CHAIN_LEN-1:0] exp_reg;
  logic [CHAIN_LEN-1:0] prev_exp_reg;
  logic [CHAIN_LEN-1:0] cmp_vec;
  logic                 shift_last;
  logic                 last_pat;
  logic                 cmp_en;
  logic                 cmp_last;
  logic                 pat_fail;

  assign shift_last = (shift_cnt == LAST_BIT);
  assign last_pat   = (pat_cnt == num_pat_reg - PAT_W'(1));
  assign bit_idx    = LAST_BIT - shift_cnt;

  // All scan-side outputs decode from registered state only.
  assign pat_ready  = (state == ST_LOAD);
  assign scan_en    = (state == ST_SHIFT) || (state == ST_UNLOAD);
  assign capture_en = (state == ST_CAPTURE);
  assign scan_in    = (state == ST_SHIFT) ? stim_reg[bit_idx] : 1'b0;
  assign busy       = (state == ST_LOAD) || (state == ST_SHIFT) ||
                      (state == ST_CAPTURE) || (state == ST_UNLOAD);
  assign done       = (state == ST_DONE);
  assign fail       = (fail_cnt != '0);

  // While shifting pattern N in, the chain still holds the response of N-1.
  assign cmp_en   = ((state == ST_SHIFT) && (pat_cnt != '0)) || (state == ST_UNLOAD);
  assign cmp_last = scan_en && shift_last;
  assign cmp_vec  = (state == ST_UNLOAD) ? exp_reg : prev_exp_reg;

  scan_cmp #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .en       (cmp_en),
    .last     (cmp_last),
    .exp_vec  (cmp_vec),
    .idx      (bit_idx),
    .scan_out (scan_out),
    .pat_fail (pat_fail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = (num_pat == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD:    if (pat_valid) state_next = ST_SHIFT;
      ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = last_pat ? ST_UNLOAD : ST_LOAD;
      ST_UNLOAD:  if (shift_last) state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt    <= '0;
      pat_cnt      <= '0;
      num_pat_reg  <= '0;
      stim_reg     <= '0;
      exp_reg      <= '0;
      prev_exp_reg <= '0;
      fail_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_pat_reg <= num_pat;
            pat_cnt     <= '0;
            shift_cnt   <= '0;
            fail_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          if (pat_valid) begin
            stim_reg     <= pat_stim;
            exp_reg      <= pat_exp;
            prev_exp_reg <= exp_reg;
            shift_cnt    <= '0;
          end
        end
        ST_SHIFT, ST_UNLOAD: begin
          shift_cnt <= shift_last ? '0 : shift_cnt + CNT_W'(1);
          if (cmp_last && pat_fail && (fail_cnt != '1)) begin
            fail_cnt <= fail_cnt + PAT_W'(1);
          end
        end
        ST_CAPTURE: pat_cnt <= pat_cnt + PAT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl driving a 4-flop shift-register chain model.
module tb_scan_test_ctrl;

  localparam int CL = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, pat_valid, pat_ready;
  logic [PW-1:0] num_pat, fail_cnt;
  logic [CL-1:0] pat_stim, pat_exp;
  logic          scan_en, scan_in, scan_out, capture_en, busy, done, fail;

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] stim_tab [2];
  logic [CL-1:0] exp_tab  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, se_cnt, cap_cnt, both_cnt, stall_bad;
  logic [15:0] se_bits;
  bit got_done;

  always #5 clk = ~clk;

  assign scan_out = chain[CL-1];
  always @(posedge clk) if (scan_en) chain <= {chain[CL-2:0], scan_in};

  scan_test_ctrl #(.CHAIN_LEN(CL), .PAT_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pat(num_pat),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_stim(pat_stim), .pat_exp(pat_exp),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .capture_en(capture_en),
    .busy(busy), .done(done), .fail(fail), .fail_cnt(fail_cnt)
  );

  // Runs one test from IDLE/DONE; stall delays the first transfer, mid_at pulses start.
  task automatic run(input logic [PW-1:0] np, input int stall, input int mid_at);
    int k = 0;
    int stall_left = stall;
    cyc = 0; se_cnt = 0; cap_cnt = 0; both_cnt = 0; stall_bad = 0; se_bits = '0; got_done = 0;
    @(negedge clk);
    num_pat = np; start = 1'b1; pat_valid = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      start = (mid_at != 0) && (i + 1 == mid_at);
      cyc++;
      if (done) begin
        got_done = 1;
      end else begin
        if (scan_en) begin se_cnt++; se_bits = {se_bits[14:0], scan_in}; end
        if (capture_en) cap_cnt++;
        if (scan_en && capture_en) both_cnt++;
        if (pat_ready) begin
          if (stall_left > 0) begin
            pat_valid = 1'b0;
            if (scan_en || capture_en) stall_bad++;
            stall_left--;
          end else begin
            pat_valid = 1'b1; pat_stim = stim_tab[k % 2]; pat_exp = exp_tab[k % 2]; k++;
          end
        end else begin
          pat_valid = 1'b0;
        end
      end
    end
    start = 1'b0; pat_valid = 1'b0;
    n_checks++;
    if (!got_done) begin n_fail++; $display("FAIL run_timeout: done never seen after %0d cycles", cyc); end
    $display("run np=%0d stall=%0d: cycles=%0d scan_en=%0d capture=%0d fail_cnt=%0d", np, stall, cyc, se_cnt, cap_cnt, fail_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_pat = '0; pat_valid = 1'b0; pat_stim = '0; pat_exp = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({scan_en, scan_in, capture_en, pat_ready, busy, done, fail} !== 7'b0 || fail_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%0d, want 0000000/0", {scan_en, scan_in, capture_en, pat_ready, busy, done, fail}, fail_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done); end
  endtask

  task automatic test_pass();
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0110;
    run(8'd2, 0, 0);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL pass_cycles: got %0d, want 17", cyc); end
    n_checks++; if (se_cnt !== 12 || cap_cnt !== 2) begin n_fail++; $display("FAIL pass_active: scan_en=%0d capture=%0d, want 12 2", se_cnt, cap_cnt); end
    n_checks++; if (se_bits[11:0] !== 12'b1010_0110_0000) begin n_fail++; $display("FAIL pass_scan_in: got %b, want 101001100000", se_bits[11:0]); end
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL pass_exclusive: overlap cycles=%0d, want 0", both_cnt); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || fail !== 1'b0 || fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL pass_status: done=%b busy=%b fail=%b fail_cnt=%0d, want 1 0 0 0", done, busy, fail, fail_cnt);
    end
  endtask

  task automatic test_fail_last();
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0111;
    run(8'd2, 0, 0);
    n_checks++; if (done !== 1'b1 || fail !== 1'b1 || fail_cnt !== 8'd1) begin
      n_fail++; $display("FAIL fail_last: done=%b fail=%b fail_cnt=%0d, want 1 1 1", done, fail, fail_cnt);
    end
  endtask

  task automatic test_fail_multi();
    // First exp wrong in all four bits: one failing pattern, not four.
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b0101; exp_tab[1] = 4'b0110;
    run(8'd2, 0, 0);
    n_checks++; if (fail_cnt !== 8'd1 || fail !== 1'b1) begin n_fail++; $display("FAIL fail_multi_bit: fail_cnt=%0d fail=%b, want 1 1", fail_cnt, fail); end
    // MSB mismatch on pattern 0 plus LSB mismatch on pattern 1.
    exp_tab[0] = 4'b0010; exp_tab[1] = 4'b0111;
    run(8'd2, 0, 0);
    n_checks++; if (fail_cnt !== 8'd2) begin n_fail++; $display("FAIL fail_both: fail_cnt=%0d, want 2", fail_cnt); end
  endtask

  task automatic test_zero_pat();
    run(8'd0, 0, 0);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d cycles, want 1", cyc); end
    n_checks++; if (se_cnt !== 0 || fail !== 1'b0 || fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL zero_status: scan_en=%0d fail=%b fail_cnt=%0d, want 0 0 0", se_cnt, fail, fail_cnt);
    end
  endtask

  task automatic test_stall();
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0110;
    run(8'd2, 5, 0);
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_quiet: active stall cycles=%0d, want 0", stall_bad); end
    n_checks++; if (cyc !== 22 || se_cnt !== 12) begin n_fail++; $display("FAIL stall_timing: cycles=%0d scan_en=%0d, want 22 12", cyc, se_cnt); end
    n_checks++; if (fail_cnt !== 8'd0 || done !== 1'b1) begin n_fail++; $display("FAIL stall_status: fail_cnt=%0d done=%b, want 0 1", fail_cnt, done); end
  endtask

  task automatic test_reset_mid();
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b0101; exp_tab[1] = 4'b0111;
    run(8'd2, 0, 0);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (fail_cnt !== 8'd0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_clears_done: fail_cnt=%0d done=%b, want 0 0", fail_cnt, done); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); num_pat = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0; pat_valid = 1'b1; pat_stim = 4'b1010; pat_exp = 4'b1010;
    @(negedge clk); pat_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (scan_en !== 1'b1 || scan_in !== 1'b1) begin n_fail++; $display("FAIL shift2_before_reset: scan_en=%b scan_in=%b, want 1 1", scan_en, scan_in); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({scan_en, scan_in, capture_en, pat_ready, busy, done, fail} !== 7'b0 || fail_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: got %b/%0d, want 0000000/0", {scan_en, scan_in, capture_en, pat_ready, busy, done, fail}, fail_cnt);
    end
    @(negedge clk); rst = 1'b0;
    exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0110;
    run(8'd2, 0, 0);
    n_checks++; if (cyc !== 17 || fail_cnt !== 8'd0 || done !== 1'b1) begin
      n_fail++; $display("FAIL rerun_after_reset: cycles=%0d fail_cnt=%0d done=%b, want 17 0 1", cyc, fail_cnt, done);
    end
  endtask

  task automatic test_back_to_back();
    stim_tab[0] = 4'b1010; stim_tab[1] = 4'b0110; exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0111;
    run(8'd2, 0, 6);
    n_checks++; if (cyc !== 17 || se_cnt !== 12 || cap_cnt !== 2) begin
      n_fail++; $display("FAIL start_while_busy: cycles=%0d scan_en=%0d capture=%0d, want 17 12 2", cyc, se_cnt, cap_cnt);
    end
    n_checks++; if (fail_cnt !== 8'd1) begin n_fail++; $display("FAIL busy_run_result: fail_cnt=%0d, want 1", fail_cnt); end
    // Restart directly from DONE: fail_cnt clears and a clean run follows.
    exp_tab[1] = 4'b0110;
    run(8'd2, 0, 0);
    n_checks++; if (fail_cnt !== 8'd0 || cyc !== 17) begin n_fail++; $display("FAIL restart_from_done: fail_cnt=%0d cycles=%0d, want 0 17", fail_cnt, cyc); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_last();
    test_fail_multi();
    test_zero_pat();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
